// File: rtl/mem2axi_master.sv
// mem2axi_master: converts a simple req/gnt memory port into single-beat
// AXI4 read and write transactions, with one transaction in flight at a time.
module mem2axi_master #(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 11,
  parameter int AXI_USER_WIDTH = 1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  // memory side
  input  logic                        mem_req_i,
  output logic                        mem_gnt_o,
  input  logic                        mem_we_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   mem_addr_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] mem_be_i,
  input  logic [AXI_DATA_WIDTH-1:0]   mem_data_i,
  output logic                        mem_rvalid_o,
  output logic [AXI_DATA_WIDTH-1:0]   mem_data_o,
  output logic                        mem_err_o,
  // AXI write address
  output logic [AXI_ID_WIDTH-1:0]     axi_aw_awid,
  output logic [AXI_ADDR_WIDTH-1:0]   axi_aw_awaddr,
  output logic [7:0]                  axi_aw_awlen,
  output logic [2:0]                  axi_aw_awsize,
  output logic [1:0]                  axi_aw_awburst,
  output logic                        axi_aw_awlock,
  output logic [3:0]                  axi_aw_awcache,
  output logic [2:0]                  axi_aw_awprot,
  output logic [3:0]                  axi_aw_awqos,
  output logic [3:0]                  axi_aw_awregion,
  output logic [AXI_USER_WIDTH-1:0]   axi_aw_awuser,
  output logic                        axi_aw_awvalid,
  input  logic                        axi_aw_awready,
  // AXI write data
  output logic [AXI_DATA_WIDTH-1:0]   axi_w_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] axi_w_wstrb,
  output logic                        axi_w_wlast,
  output logic [AXI_USER_WIDTH-1:0]   axi_w_wuser,
  output logic                        axi_w_wvalid,
  input  logic                        axi_w_wready,
  // AXI write response
  input  logic [AXI_ID_WIDTH-1:0]     axi_b_bid,
  input  logic [1:0]                  axi_b_bresp,
  input  logic [AXI_USER_WIDTH-1:0]   axi_b_buser,
  input  logic                        axi_b_bvalid,
  output logic                        axi_b_bready,
  // AXI read address
  output logic [AXI_ID_WIDTH-1:0]     axi_ar_arid,
  output logic [AXI_ADDR_WIDTH-1:0]   axi_ar_araddr,
  output logic [7:0]                  axi_ar_arlen,
  output logic [2:0]                  axi_ar_arsize,
  output logic [1:0]                  axi_ar_arburst,
  output logic                        axi_ar_arlock,
  output logic [3:0]                  axi_ar_arcache,
  output logic [2:0]                  axi_ar_arprot,
  output logic [3:0]                  axi_ar_arqos,
  output logic [3:0]                  axi_ar_arregion,
  output logic [AXI_USER_WIDTH-1:0]   axi_ar_aruser,
  output logic                        axi_ar_arvalid,
  input  logic                        axi_ar_arready,
  // AXI read data
  input  logic [AXI_ID_WIDTH-1:0]     axi_r_rid,
  input  logic [AXI_DATA_WIDTH-1:0]   axi_r_rdata,
  input  logic [1:0]                  axi_r_rresp,
  input  logic                        axi_r_rlast,
  input  logic [AXI_USER_WIDTH-1:0]   axi_r_ruser,
  input  logic                        axi_r_rvalid,
  output logic                        axi_r_rready
);

  // Every transfer is one full-width beat.
  localparam logic [2:0] LP_SIZE = 3'($clog2(AXI_DATA_WIDTH/8));

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4
  } state_t;

  state_t                        r_state;
  state_t                        w_state_next;
  logic                          r_we;
  logic [AXI_ADDR_WIDTH-1:0]     r_addr;
  logic [AXI_DATA_WIDTH/8-1:0]   r_be;
  logic [AXI_DATA_WIDTH-1:0]     r_data;
  logic                          r_aw_done;
  logic                          r_w_done;
  logic                          r_rvalid;
  logic                          r_err;
  logic [AXI_DATA_WIDTH-1:0]     r_rdata;

  logic                          w_gnt;
  logic                          w_awvalid;
  logic                          w_wvalid;
  logic                          w_bready;
  logic                          w_arvalid;
  logic                          w_rready;
  logic                          w_aw_hs;
  logic                          w_w_hs;
  logic                          w_b_hs;
  logic                          w_r_hs;
  logic                          w_unused;

  assign w_aw_hs = w_awvalid & axi_aw_awready;
  assign w_w_hs  = w_wvalid  & axi_w_wready;
  assign w_b_hs  = w_bready  & axi_b_bvalid;
  assign w_r_hs  = w_rready  & axi_r_rvalid;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  // Next-state and handshake outputs; AW and W each retire independently.
  always_comb begin
    w_state_next = r_state;
    w_gnt        = 1'b0;
    w_awvalid    = 1'b0;
    w_wvalid     = 1'b0;
    w_bready     = 1'b0;
    w_arvalid    = 1'b0;
    w_rready     = 1'b0;
    case (r_state)
      IDLE: begin
        if (mem_req_i) begin
          w_gnt        = 1'b1;
          w_state_next = mem_we_i ? WR_REQ : RD_REQ;
        end
      end
      WR_REQ: begin
        w_awvalid = ~r_aw_done;
        w_wvalid  = ~r_w_done;
        if ((r_aw_done | (~r_aw_done & axi_aw_awready)) &&
            (r_w_done  | (~r_w_done  & axi_w_wready)))
          w_state_next = WR_RESP;
      end
      WR_RESP: begin
        w_bready = 1'b1;
        if (axi_b_bvalid) w_state_next = IDLE;
      end
      RD_REQ: begin
        w_arvalid = 1'b1;
        if (axi_ar_arready) w_state_next = RD_RESP;
      end
      RD_RESP: begin
        w_rready = 1'b1;
        if (axi_r_rvalid) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Capture the memory request on grant; it stays put until the next grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_be   <= '0;
      r_data <= '0;
    end else if (w_gnt) begin
      r_we   <= mem_we_i;
      r_addr <= mem_addr_i;
      r_be   <= mem_be_i;
      r_data <= mem_data_i;
    end
  end

  // Remember which of AW / W has already been accepted in this write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else if (w_gnt) begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      if (w_aw_hs) r_aw_done <= 1'b1;
      if (w_w_hs)  r_w_done  <= 1'b1;
    end
  end

  // Completion pulse, error flag and read data, registered off the response handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= w_b_hs | w_r_hs;
      if (w_b_hs) r_err <= axi_b_bresp[1];
      if (w_r_hs) begin
        r_err   <= axi_r_rresp[1];
        r_rdata <= axi_r_rdata;
      end
    end
  end

  // Grant is combinational but must stay low while reset is held.
  assign mem_gnt_o    = w_gnt & rst_ni;
  assign mem_rvalid_o = r_rvalid;
  assign mem_err_o    = r_err;
  assign mem_data_o   = r_rdata;

  assign axi_aw_awid     = '0;
  assign axi_aw_awaddr   = r_addr;
  assign axi_aw_awlen    = 8'd0;
  assign axi_aw_awsize   = LP_SIZE;
  assign axi_aw_awburst  = 2'b01;
  assign axi_aw_awlock   = 1'b0;
  assign axi_aw_awcache  = 4'b0000;
  assign axi_aw_awprot   = 3'b000;
  assign axi_aw_awqos    = 4'd0;
  assign axi_aw_awregion = 4'd0;
  assign axi_aw_awuser   = '0;
  assign axi_aw_awvalid  = w_awvalid;

  assign axi_w_wdata  = r_data;
  assign axi_w_wstrb  = r_be;
  assign axi_w_wlast  = 1'b1;
  assign axi_w_wuser  = '0;
  assign axi_w_wvalid = w_wvalid;

  assign axi_b_bready = w_bready;

  assign axi_ar_arid     = '0;
  assign axi_ar_araddr   = r_addr;
  assign axi_ar_arlen    = 8'd0;
  assign axi_ar_arsize   = LP_SIZE;
  assign axi_ar_arburst  = 2'b01;
  assign axi_ar_arlock   = 1'b0;
  assign axi_ar_arcache  = 4'b0000;
  assign axi_ar_arprot   = 3'b000;
  assign axi_ar_arqos    = 4'd0;
  assign axi_ar_arregion = 4'd0;
  assign axi_ar_aruser   = '0;
  assign axi_ar_arvalid  = w_arvalid;

  assign axi_r_rready = w_rready;

  // IDs, user bits, rlast and the low response bit carry no meaning here.
  assign w_unused = ^{axi_b_bid, axi_b_bresp[0], axi_b_buser, axi_r_rid,
                      axi_r_rresp[0], axi_r_rlast, axi_r_ruser, r_we};

endmodule

// File: tb/tb_mem2axi_master.sv
// tb_mem2axi_master: directed checks of mem2axi_master against a small
// reactive AXI slave with programmable ready delays and responses.
module tb_mem2axi_master;

  localparam int AW = 64;
  localparam int DW = 32;
  localparam int IW = 11;
  localparam int UW = 1;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;

  logic          mem_req_i = 1'b0;
  logic          mem_gnt_o;
  logic          mem_we_i = 1'b0;
  logic [AW-1:0] mem_addr_i = '0;
  logic [DW/8-1:0] mem_be_i = '0;
  logic [DW-1:0] mem_data_i = '0;
  logic          mem_rvalid_o;
  logic [DW-1:0] mem_data_o;
  logic          mem_err_o;

  logic [IW-1:0] axi_aw_awid;
  logic [AW-1:0] axi_aw_awaddr;
  logic [7:0]    axi_aw_awlen;
  logic [2:0]    axi_aw_awsize;
  logic [1:0]    axi_aw_awburst;
  logic          axi_aw_awlock;
  logic [3:0]    axi_aw_awcache;
  logic [2:0]    axi_aw_awprot;
  logic [3:0]    axi_aw_awqos;
  logic [3:0]    axi_aw_awregion;
  logic [UW-1:0] axi_aw_awuser;
  logic          axi_aw_awvalid;
  logic          axi_aw_awready = 1'b0;
  logic [DW-1:0] axi_w_wdata;
  logic [DW/8-1:0] axi_w_wstrb;
  logic          axi_w_wlast;
  logic [UW-1:0] axi_w_wuser;
  logic          axi_w_wvalid;
  logic          axi_w_wready = 1'b0;
  logic [IW-1:0] axi_b_bid = '0;
  logic [1:0]    axi_b_bresp = 2'b00;
  logic [UW-1:0] axi_b_buser = '0;
  logic          axi_b_bvalid = 1'b0;
  logic          axi_b_bready;
  logic [IW-1:0] axi_ar_arid;
  logic [AW-1:0] axi_ar_araddr;
  logic [7:0]    axi_ar_arlen;
  logic [2:0]    axi_ar_arsize;
  logic [1:0]    axi_ar_arburst;
  logic          axi_ar_arlock;
  logic [3:0]    axi_ar_arcache;
  logic [2:0]    axi_ar_arprot;
  logic [3:0]    axi_ar_arqos;
  logic [3:0]    axi_ar_arregion;
  logic [UW-1:0] axi_ar_aruser;
  logic          axi_ar_arvalid;
  logic          axi_ar_arready = 1'b0;
  logic [IW-1:0] axi_r_rid = '0;
  logic [DW-1:0] axi_r_rdata = '0;
  logic [1:0]    axi_r_rresp = 2'b00;
  logic          axi_r_rlast = 1'b0;
  logic [UW-1:0] axi_r_ruser = '0;
  logic          axi_r_rvalid = 1'b0;
  logic          axi_r_rready;

  mem2axi_master #(
    .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW), .AXI_USER_WIDTH(UW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .mem_req_i(mem_req_i), .mem_gnt_o(mem_gnt_o), .mem_we_i(mem_we_i),
    .mem_addr_i(mem_addr_i), .mem_be_i(mem_be_i), .mem_data_i(mem_data_i),
    .mem_rvalid_o(mem_rvalid_o), .mem_data_o(mem_data_o), .mem_err_o(mem_err_o),
    .axi_aw_awid(axi_aw_awid), .axi_aw_awaddr(axi_aw_awaddr), .axi_aw_awlen(axi_aw_awlen),
    .axi_aw_awsize(axi_aw_awsize), .axi_aw_awburst(axi_aw_awburst), .axi_aw_awlock(axi_aw_awlock),
    .axi_aw_awcache(axi_aw_awcache), .axi_aw_awprot(axi_aw_awprot), .axi_aw_awqos(axi_aw_awqos),
    .axi_aw_awregion(axi_aw_awregion), .axi_aw_awuser(axi_aw_awuser),
    .axi_aw_awvalid(axi_aw_awvalid), .axi_aw_awready(axi_aw_awready),
    .axi_w_wdata(axi_w_wdata), .axi_w_wstrb(axi_w_wstrb), .axi_w_wlast(axi_w_wlast),
    .axi_w_wuser(axi_w_wuser), .axi_w_wvalid(axi_w_wvalid), .axi_w_wready(axi_w_wready),
    .axi_b_bid(axi_b_bid), .axi_b_bresp(axi_b_bresp), .axi_b_buser(axi_b_buser),
    .axi_b_bvalid(axi_b_bvalid), .axi_b_bready(axi_b_bready),
    .axi_ar_arid(axi_ar_arid), .axi_ar_araddr(axi_ar_araddr), .axi_ar_arlen(axi_ar_arlen),
    .axi_ar_arsize(axi_ar_arsize), .axi_ar_arburst(axi_ar_arburst), .axi_ar_arlock(axi_ar_arlock),
    .axi_ar_arcache(axi_ar_arcache), .axi_ar_arprot(axi_ar_arprot), .axi_ar_arqos(axi_ar_arqos),
    .axi_ar_arregion(axi_ar_arregion), .axi_ar_aruser(axi_ar_aruser),
    .axi_ar_arvalid(axi_ar_arvalid), .axi_ar_arready(axi_ar_arready),
    .axi_r_rid(axi_r_rid), .axi_r_rdata(axi_r_rdata), .axi_r_rresp(axi_r_rresp),
    .axi_r_rlast(axi_r_rlast), .axi_r_ruser(axi_r_ruser),
    .axi_r_rvalid(axi_r_rvalid), .axi_r_rready(axi_r_rready)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // slave configuration, owned by the stimulus process
  int          aw_wait = 0;
  int          w_wait = 0;
  int          ar_wait = 0;
  logic [1:0]  bresp_cfg = 2'b00;
  logic [1:0]  rresp_cfg = 2'b00;
  logic [DW-1:0] rdata_cfg = '0;
  logic        r_hold = 1'b0;

  // reactive slave: decides its ready/valid for the coming edge at each negedge
  int aw_cnt = 0;
  int w_cnt = 0;
  int ar_cnt = 0;
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      axi_aw_awready = 1'b0; axi_w_wready = 1'b0; axi_ar_arready = 1'b0;
      axi_b_bvalid = 1'b0; axi_r_rvalid = 1'b0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
    end else begin
      if (axi_aw_awvalid) begin axi_aw_awready = (aw_cnt >= aw_wait); aw_cnt++; end
      else begin axi_aw_awready = 1'b0; aw_cnt = 0; end
      if (axi_w_wvalid) begin axi_w_wready = (w_cnt >= w_wait); w_cnt++; end
      else begin axi_w_wready = 1'b0; w_cnt = 0; end
      if (axi_ar_arvalid) begin axi_ar_arready = (ar_cnt >= ar_wait); ar_cnt++; end
      else begin axi_ar_arready = 1'b0; ar_cnt = 0; end
      axi_b_bvalid = axi_b_bready;
      axi_b_bresp  = bresp_cfg;
      axi_r_rvalid = axi_r_rready & ~r_hold;
      axi_r_rdata  = rdata_cfg;
      axi_r_rresp  = rresp_cfg;
      axi_r_rlast  = 1'b1;
    end
  end

  // monitor: a valid&ready seen here is a handshake on the next rising edge
  int aw_hs_n = 0, w_hs_n = 0, ar_hs_n = 0, b_n = 0, r_n = 0, rv_n = 0, unstable_n = 0;
  int aw_hs_cyc = 0, w_hs_cyc = 0, ar_hs_cyc = 0, rv_cyc = 0;
  int aw_run = 0, w_run = 0, aw_run_hs = 0, w_run_hs = 0;
  logic [AW-1:0] aw_prev = '0;
  logic [DW-1:0] w_prev = '0;
  logic [AW-1:0] cap_awaddr = '0, cap_araddr = '0;
  logic [7:0]    cap_awlen = '0, cap_arlen = '0;
  logic [2:0]    cap_awsize = '0, cap_arsize = '0;
  logic [1:0]    cap_awburst = '0, cap_arburst = '0;
  logic [DW-1:0] cap_wdata = '0, rv_data = '0;
  logic [DW/8-1:0] cap_wstrb = '0;
  logic          cap_wlast = 1'b0, rv_err = 1'b0;
  always @(negedge clk_i) begin
    #2;
    if (axi_aw_awvalid) begin
      aw_run++;
      if (aw_run > 1 && axi_aw_awaddr != aw_prev) unstable_n++;
      aw_prev = axi_aw_awaddr;
      if (axi_aw_awready) begin
        aw_hs_n++; aw_hs_cyc = cyc; aw_run_hs = aw_run;
        cap_awaddr = axi_aw_awaddr; cap_awlen = axi_aw_awlen;
        cap_awsize = axi_aw_awsize; cap_awburst = axi_aw_awburst;
      end
    end else aw_run = 0;
    if (axi_w_wvalid) begin
      w_run++;
      if (w_run > 1 && axi_w_wdata != w_prev) unstable_n++;
      w_prev = axi_w_wdata;
      if (axi_w_wready) begin
        w_hs_n++; w_hs_cyc = cyc; w_run_hs = w_run;
        cap_wdata = axi_w_wdata; cap_wstrb = axi_w_wstrb; cap_wlast = axi_w_wlast;
      end
    end else w_run = 0;
    if (axi_ar_arvalid && axi_ar_arready) begin
      ar_hs_n++; ar_hs_cyc = cyc;
      cap_araddr = axi_ar_araddr; cap_arlen = axi_ar_arlen;
      cap_arsize = axi_ar_arsize; cap_arburst = axi_ar_arburst;
    end
    if (axi_b_bvalid && axi_b_bready) b_n++;
    if (axi_r_rvalid && axi_r_rready) r_n++;
    if (mem_rvalid_o) begin rv_n++; rv_cyc = cyc; rv_data = mem_data_o; rv_err = mem_err_o; end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // issue one request at the next negedge; g returns the grant cycle
  task automatic do_req(input logic we, input logic [AW-1:0] addr,
                        input logic [DW/8-1:0] be, input logic [DW-1:0] data, output int g);
    @(negedge clk_i);
    #1;
    mem_req_i = 1'b1; mem_we_i = we; mem_addr_i = addr; mem_be_i = be; mem_data_i = data;
    #1;
    check("gnt", 64'(mem_gnt_o), 64'd1);
    g = cyc;
    @(posedge clk_i);
    #1;
    mem_req_i = 1'b0;
    $display("txn we=%0d addr=%0h be=%0h data=%0h granted at cycle %0d", we, addr, be, data, g);
  endtask

  int g, g2, b_rv, b_b, b_aw, b_w, b_ar, b_un;
  bit seen;

  task automatic snap();
    b_rv = rv_n; b_b = b_n; b_aw = aw_hs_n; b_w = w_hs_n; b_ar = ar_hs_n; b_un = unstable_n;
  endtask

  initial begin
    // reset state, including grant suppressed while reset is held
    mem_req_i = 1'b1;
    repeat (2) @(negedge clk_i);
    #3;
    check("rst_gnt", 64'(mem_gnt_o), 64'd0);
    check("rst_valids", 64'({axi_aw_awvalid, axi_w_wvalid, axi_ar_arvalid, axi_b_bready, axi_r_rready}), 64'd0);
    check("rst_rvalid", 64'(mem_rvalid_o), 64'd0);
    check("rst_err", 64'(mem_err_o), 64'd0);
    check("rst_data", 64'(mem_data_o), 64'd0);
    mem_req_i = 1'b0;
    @(negedge clk_i);
    #1 rst_ni = 1'b1;

    // zero-wait write
    snap();
    do_req(1'b1, 64'h1000, 4'hF, 32'hDEADBEEF, g);
    repeat (8) @(negedge clk_i);
    #3;
    check("wr_aw_cyc", 64'(aw_hs_cyc - g), 64'd1);
    check("wr_w_cyc", 64'(w_hs_cyc - g), 64'd1);
    check("wr_awaddr", cap_awaddr, 64'h1000);
    check("wr_awlen", 64'(cap_awlen), 64'd0);
    check("wr_awsize", 64'(cap_awsize), 64'd2);
    check("wr_awburst", 64'(cap_awburst), 64'd1);
    check("wr_wdata", 64'(cap_wdata), 64'hDEADBEEF);
    check("wr_wstrb", 64'(cap_wstrb), 64'hF);
    check("wr_wlast", 64'(cap_wlast), 64'd1);
    check("wr_b_count", 64'(b_n - b_b), 64'd1);
    check("wr_rv_cyc", 64'(rv_cyc - g), 64'd3);
    check("wr_rv_count", 64'(rv_n - b_rv), 64'd1);
    check("wr_err", 64'(rv_err), 64'd0);

    // zero-wait read
    snap();
    rdata_cfg = 32'h12345678;
    do_req(1'b0, 64'h2004, 4'h0, 32'h0, g);
    repeat (8) @(negedge clk_i);
    #3;
    check("rd_ar_cyc", 64'(ar_hs_cyc - g), 64'd1);
    check("rd_araddr", cap_araddr, 64'h2004);
    check("rd_arlen", 64'(cap_arlen), 64'd0);
    check("rd_arsize", 64'(cap_arsize), 64'd2);
    check("rd_arburst", 64'(cap_arburst), 64'd1);
    check("rd_rv_cyc", 64'(rv_cyc - g), 64'd3);
    check("rd_data", 64'(rv_data), 64'h12345678);
    check("rd_err", 64'(rv_err), 64'd0);
    check("rd_rv_count", 64'(rv_n - b_rv), 64'd1);

    // write with awready held off three cycles, wready immediate
    snap();
    aw_wait = 3;
    do_req(1'b1, 64'h4010, 4'h3, 32'hCAFE0001, g);
    repeat (12) @(negedge clk_i);
    #3;
    aw_wait = 0;
    check("aww_w_len", 64'(w_run_hs), 64'd1);
    check("aww_aw_len", 64'(aw_run_hs), 64'd4);
    check("aww_aw_cyc", 64'(aw_hs_cyc - g), 64'd4);
    check("aww_w_count", 64'(w_hs_n - b_w), 64'd1);
    check("aww_aw_count", 64'(aw_hs_n - b_aw), 64'd1);
    check("aww_stable", 64'(unstable_n - b_un), 64'd0);
    check("aww_b_count", 64'(b_n - b_b), 64'd1);
    check("aww_rv_count", 64'(rv_n - b_rv), 64'd1);
    check("aww_rv_cyc", 64'(rv_cyc - g), 64'd6);
    check("aww_data_held", 64'(mem_data_o), 64'h12345678);

    // back-to-back: read granted while the write completion pulse is high
    snap();
    rdata_cfg = 32'hA5A55A5A;
    do_req(1'b1, 64'h5000, 4'hF, 32'h11112222, g);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk_i);
      #3;
      if (mem_rvalid_o) seen = 1'b1;
    end
    check("b2b_wr_done", 64'(seen), 64'd1);
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 64'h3008;
    #1;
    check("b2b_gnt", 64'(mem_gnt_o), 64'd1);
    g2 = cyc;
    @(posedge clk_i);
    #1 mem_req_i = 1'b0;
    $display("txn we=0 addr=3008 granted at cycle %0d (back-to-back)", g2);
    @(negedge clk_i);
    #1;
    check("b2b_arvalid", 64'(axi_ar_arvalid), 64'd1);
    repeat (8) @(negedge clk_i);
    #3;
    check("b2b_ar_cyc", 64'(ar_hs_cyc - g2), 64'd1);
    check("b2b_araddr", cap_araddr, 64'h3008);
    check("b2b_rv_count", 64'(rv_n - b_rv), 64'd2);
    check("b2b_data", 64'(rv_data), 64'hA5A55A5A);

    // read returning SLVERR
    snap();
    rdata_cfg = 32'hCAFEF00D;
    rresp_cfg = 2'b10;
    do_req(1'b0, 64'h6000, 4'h0, 32'h0, g);
    repeat (8) @(negedge clk_i);
    #3;
    rresp_cfg = 2'b00;
    check("slverr_err", 64'(rv_err), 64'd1);
    check("slverr_rv_cyc", 64'(rv_cyc - g), 64'd3);
    check("slverr_data", 64'(rv_data), 64'hCAFEF00D);

    // reset while waiting in RD_RESP
    snap();
    r_hold = 1'b1;
    rdata_cfg = 32'h0BADF00D;
    do_req(1'b0, 64'h7000, 4'h0, 32'h0, g);
    repeat (2) @(negedge clk_i);
    #3;
    check("rr_rready", 64'(axi_r_rready), 64'd1);
    rst_ni = 1'b0;
    mem_req_i = 1'b1;
    #1;
    check("rr_gnt", 64'(mem_gnt_o), 64'd0);
    check("rr_valids", 64'({axi_aw_awvalid, axi_w_wvalid, axi_ar_arvalid, axi_b_bready, axi_r_rready}), 64'd0);
    check("rr_rvalid", 64'(mem_rvalid_o), 64'd0);
    check("rr_err", 64'(mem_err_o), 64'd0);
    check("rr_data", 64'(mem_data_o), 64'd0);
    mem_req_i = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    rst_ni = 1'b1;
    r_hold = 1'b0;
    check("rr_no_pulse", 64'(rv_n - b_rv), 64'd0);
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 64'h7004;
    #1;
    check("rr_gnt_after", 64'(mem_gnt_o), 64'd1);
    g = cyc;
    @(posedge clk_i);
    #1 mem_req_i = 1'b0;
    $display("txn we=0 addr=7004 granted at cycle %0d (after reset)", g);
    repeat (8) @(negedge clk_i);
    #3;
    check("rr_rv_count", 64'(rv_n - b_rv), 64'd1);
    check("rr_rv_cyc", 64'(rv_cyc - g), 64'd3);
    check("rr_new_data", 64'(rv_data), 64'h0BADF00D);
    check("rr_new_err", 64'(rv_err), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // hard stop so the run can never hang
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
